// File: rtl/kb_rx_ctrl_if.sv
// Consumer-side bundle of the PS/2 receive controller: decoded scancode
// handshake, error pulses, status flags and a debug view of the FSM state.
interface kb_rx_ctrl_if;
    logic [7:0] code;
    logic       is_break;
    logic       is_ext;
    logic       code_valid;
    logic       code_ready;
    logic       err_parity;
    logic       err_frame;
    logic       overrun;
    logic       busy;
    logic [1:0] dbg_state;

    // Handshake: a code transfers on every cycle where code_valid and
    // code_ready are both 1. While code_valid=1 and code_ready=0, the
    // producer holds code/is_break/is_ext stable. code_ready may change
    // freely and does not have to wait for code_valid.
    modport master (
        output code, is_break, is_ext, code_valid,
        output err_parity, err_frame, overrun, busy, dbg_state,
        input  code_ready
    );

    modport slave (
        input  code, is_break, is_ext, code_valid,
        input  err_parity, err_frame, overrun, busy, dbg_state,
        output code_ready
    );
endinterface

// File: rtl/kb_rx_ctrl.sv
// PS/2 keyboard receiver.
// - Synchronises the keyboard clock and data pins.
// - Assembles 11-bit frames and checks odd parity and the stop bit.
// - Strips the 0xE0 (extended) and 0xF0 (break) prefixes into flags.
// - Presents each scancode through a valid/ready handshake.
module kb_rx_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    kb_rx_ctrl_if.master  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [9:0]             frame_q, frame_d;
    logic                   ext_pend_q, ext_pend_d;
    logic                   brk_pend_q, brk_pend_d;
    logic [7:0]             code_q, code_d;
    logic                   is_break_q, is_break_d;
    logic                   is_ext_q, is_ext_d;
    logic                   code_valid_q, code_valid_d;
    logic                   err_parity_q, err_parity_d;
    logic                   err_frame_q, err_frame_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;

    logic ps2_clk_s, ps2_data_s, fall;
    logic stop_ok, parity_ok;

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign fall       = clk_prev_q & ~ps2_clk_s;
    assign stop_ok    = frame_q[9];
    assign parity_ok  = ^frame_q[8:0];

    // Next-state logic for the synchroniser, frame receiver and output handshake.
    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d   = ps2_clk_s;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        tmo_d        = tmo_q;
        frame_d      = frame_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        code_d       = code_q;
        is_break_d   = is_break_q;
        is_ext_d     = is_ext_q;
        code_valid_d = code_valid_q;
        err_parity_d = 1'b0;
        err_frame_d  = 1'b0;
        overrun_d    = overrun_q;

        // The consumer took the code; a load in CHECK below may override this.
        if (code_valid_q && bus.code_ready) begin
            code_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (!ps2_data_s) begin
                        state_d   = RECV;
                        bit_cnt_d = 4'd0;
                        tmo_d     = '0;
                    end else begin
                        // The start bit must be 0.
                        err_frame_d = 1'b1;
                        ext_pend_d  = 1'b0;
                        brk_pend_d  = 1'b0;
                    end
                end
            end
            RECV: begin
                if (fall) begin
                    // Shift in from the top so that after 10 edges:
                    // [7:0] = data (LSB first), [8] = parity, [9] = stop.
                    frame_d   = {ps2_data_s, frame_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tmo_d     = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = CHECK;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // The keyboard stopped clocking mid-frame.
                    state_d     = IDLE;
                    bit_cnt_d   = 4'd0;
                    tmo_d       = '0;
                    err_frame_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            CHECK: begin
                state_d   = IDLE;
                bit_cnt_d = 4'd0;
                if (!stop_ok) begin
                    // A stop-bit failure takes precedence over a parity failure.
                    err_frame_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                end else if (!parity_ok) begin
                    err_parity_d = 1'b1;
                    ext_pend_d   = 1'b0;
                    brk_pend_d   = 1'b0;
                end else if (frame_q[7:0] == 8'hE0) begin
                    ext_pend_d = 1'b1;
                end else if (frame_q[7:0] == 8'hF0) begin
                    brk_pend_d = 1'b1;
                end else begin
                    if (!code_valid_q || bus.code_ready) begin
                        code_d       = frame_q[7:0];
                        is_break_d   = brk_pend_q;
                        is_ext_d     = ext_pend_q;
                        code_valid_d = 1'b1;
                    end else begin
                        // The output is still occupied, so the new code is dropped.
                        overrun_d = 1'b1;
                    end
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // All state, including the FSM and the registered outputs, is cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            clk_sync_q   <= '0;
            data_sync_q  <= '0;
            clk_prev_q   <= 1'b0;
            bit_cnt_q    <= 4'd0;
            tmo_q        <= '0;
            frame_q      <= 10'd0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            code_q       <= 8'd0;
            is_break_q   <= 1'b0;
            is_ext_q     <= 1'b0;
            code_valid_q <= 1'b0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            frame_q      <= frame_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            code_q       <= code_d;
            is_break_q   <= is_break_d;
            is_ext_q     <= is_ext_d;
            code_valid_q <= code_valid_d;
            err_parity_q <= err_parity_d;
            err_frame_q  <= err_frame_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.code       = code_q;
    assign bus.is_break   = is_break_q;
    assign bus.is_ext     = is_ext_q;
    assign bus.code_valid = code_valid_q;
    assign bus.err_parity = err_parity_q;
    assign bus.err_frame  = err_frame_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = busy_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: doc/kb_rx_ctrl.md
KB_RX_CTRL -- requirements
Module: kb_rx_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, meaning system-clock cycles allowed between ps2_clk falling edges inside a frame before abort.
REQ-002 Parameter SYNC_STAGES, default 2, meaning flip-flop depth of the ps2_clk and ps2_data synchronizers (minimum 2).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous and active-low.
REQ-005 ps2_clk  input  1  raw keyboard clock pin, asynchronous to clk.
REQ-006 ps2_data  input  1  raw keyboard data pin, asynchronous to clk.
REQ-007 code_ready  input  1  consumer accepts the presented code this cycle.
REQ-008 code  output  8  received scancode byte, prefixes stripped.
REQ-009 is_break  output  1  code was preceded by 0xF0 (key release).
REQ-010 is_ext  output  1  code was preceded by 0xE0 (extended key).
REQ-011 code_valid  output  1  code/is_break/is_ext hold a code awaiting acceptance.
REQ-012 err_parity  output  1  one-cycle pulse on odd-parity failure.
REQ-013 err_frame  output  1  one-cycle pulse on bad start bit, bad stop bit or timeout.
REQ-014 overrun  output  1  sticky flag: a code was dropped because the output was still occupied.
REQ-015 busy  output  1  high while a frame is in progress (state RECV or CHECK).

Function
REQ-016 Synchronize ps2_clk and ps2_data through SYNC_STAGES flops; falling edge = previous synchronized clk 1, current 0; ps2_data sampled from its synchronizer on that same cycle.
REQ-017 States IDLE, RECV, CHECK; reset state IDLE.
REQ-018 IDLE: edge with data 0 -> RECV, bit_cnt=0, timeout counter=0; edge with data 1 -> stay IDLE, err_frame pulse.
REQ-019 RECV: each edge shifts the sampled bit into a 10-bit frame register (8 data LSB-first, parity, stop) and increments bit_cnt; the edge bringing bit_cnt to 10 -> CHECK on the next cycle.
REQ-020 RECV: timeout counter clears on every edge and otherwise increments; reaching TIMEOUT_CYCLES -> IDLE, err_frame pulse, bit_cnt cleared.
REQ-021 CHECK lasts exactly one cycle and always returns to IDLE.
REQ-022 CHECK parity rule: XOR of 8 data bits and parity bit SHALL equal 1; else err_parity pulse, byte discarded.
REQ-023 CHECK stop rule: stop bit SHALL equal 1; else err_frame pulse, byte discarded; if both fail, only err_frame pulses.
REQ-024 Valid byte 0xE0 sets ext_pending; valid byte 0xF0 sets brk_pending; neither is presented on code.
REQ-025 Any other valid byte: if code_valid=0, or code_valid=1 with code_ready=1 this cycle, load code, is_break=brk_pending and is_ext=ext_pending, assert code_valid, and clear both pendings.
REQ-026 If code_valid=1 and code_ready=0 in CHECK, drop the byte, set overrun, and clear both pendings.
REQ-027 Any err_parity or err_frame event clears ext_pending and brk_pending.
REQ-028 code_valid deasserts on the cycle after code_valid and code_ready are both 1, unless REQ-025 reloads on that cycle.
REQ-029 code, is_break and is_ext stay stable while code_valid=1 and code_ready=0.
REQ-030 Latency: code_valid rises 2 clk cycles after the cycle the stop-bit falling edge is detected.
REQ-031 overrun clears only on reset.
REQ-032 Falling edges arriving during CHECK are ignored.

Reset
REQ-033 While reset_n=0, all outputs are 0, state is IDLE, pendings, counters, frame register and synchronizers clear.
REQ-034 Reset assertion mid-frame aborts the frame silently with no error pulse; the first frame after release decodes normally.

Verification
REQ-035 Frame 0x1C (bits 0,0,0,1,1,1,0,0,0 parity 0, stop 1) -> code=0x1C, is_break=0, is_ext=0, code_valid=1 two cycles after the stop edge.
REQ-036 Frames 0xF0 then 0x1C -> single code 0x1C with is_break=1; frames 0xE0,0xF0,0x75 -> code 0x75 with is_ext=1 and is_break=1.
REQ-037 Frame 0x1C with parity 1 -> one err_parity pulse, no code_valid; a following F0 prefix is not carried past a subsequent error.
REQ-038 Four bits then ps2_clk held high -> err_frame pulse exactly TIMEOUT_CYCLES after the last edge, busy=0; the next good frame decodes.
REQ-039 Codes 0x1C then 0x32 with code_ready=0 -> code stays 0x1C, overrun=1; code_ready asserted in the CHECK cycle of a third code -> third code loaded with no gap in code_valid.
REQ-040 reset_n pulsed low after bit 5 of a frame -> all outputs 0, no error pulse; a following 0x1C frame decodes correctly.
